// File: rtl/ahb2obi_pkg.sv
// Shared encodings and helpers for the AHB-Lite slave to OBI master bridge.
// Optional error reporting is enabled with the AHB2OBI_ERR_EN macro in ahb2obi_adapter.
package ahb2obi_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Sizes above a word fall into the default arm and are treated as a word.
    function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = 4'b0011 << {addr[1], 1'b0};
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic access_bad(input logic [2:0] size, input logic [1:0] addr);
        logic bad;
        case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = addr[0];
            HSIZE_WORD: bad = (addr != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb2obi_adapter.sv
// AHB-Lite slave to OBI master bridge: one outstanding transfer, HREADYOUT stretched until rvalid.
// Define AHB2OBI_ERR_EN to report OBI errors and reject oversize/misaligned accesses with ERROR.
module ahb2obi_adapter
    import ahb2obi_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
    input  logic                  hclk_i,
    input  logic                  hreset_i,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [31:0]           hwdata_i,
    input  logic                  hready_i,
    output logic                  hreadyout_o,
    output logic [1:0]            hresp_o,
    output logic [31:0]           hrdata_o,
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic [ADDR_WIDTH-1:0] obi_addr_o,
    output logic                  obi_we_o,
    output logic [3:0]            obi_be_o,
    output logic [31:0]           obi_wdata_o,
    input  logic                  obi_rvalid_i,
    input  logic [31:0]           obi_rdata_i,
    input  logic                  obi_err_i
);

    state_t                state;
    logic                  accept;
    logic                  bad;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  unused;

    assign accept      = hsel_i & htrans_i[1] & hready_i;
    assign offset      = haddr_i - BASE_ADDR;
    assign obi_wdata_o = hwdata_i;
    assign unused      = ^{hburst_i, obi_err_i};

`ifdef AHB2OBI_ERR_EN
    assign bad     = access_bad(hsize_i, haddr_i[1:0]);
    assign rsp_err = obi_err_i;
`else
    assign bad     = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            state       <= ST_IDLE;
            hreadyout_o <= 1'b1;
            hresp_o     <= HRESP_OKAY;
            hrdata_o    <= '0;
            obi_req_o   <= 1'b0;
            obi_we_o    <= 1'b0;
            obi_be_o    <= '0;
            obi_addr_o  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    if (accept && bad) begin
                        // Rejected without touching OBI; first cycle of the two-cycle ERROR.
                        state       <= ST_ERR1;
                        hreadyout_o <= 1'b0;
                        hresp_o     <= HRESP_ERROR;
                    end else if (accept) begin
                        state       <= ST_REQ;
                        hreadyout_o <= 1'b0;
                        hresp_o     <= HRESP_OKAY;
                        obi_req_o   <= 1'b1;
                        obi_we_o    <= hwrite_i;
                        obi_be_o    <= be_gen(hsize_i, haddr_i[1:0]);
                        obi_addr_o  <= {offset[ADDR_WIDTH-1:2], 2'b00};
                    end else begin
                        state       <= ST_IDLE;
                        hreadyout_o <= 1'b1;
                        hresp_o     <= HRESP_OKAY;
                    end
                end
                ST_REQ: begin
                    if (obi_gnt_i) begin
                        state     <= ST_RSP;
                        obi_req_o <= 1'b0;
                    end
                end
                ST_RSP: begin
                    if (obi_rvalid_i) begin
                        hrdata_o <= obi_rdata_i;
                        if (rsp_err) begin
                            state   <= ST_ERR1;
                            hresp_o <= HRESP_ERROR;
                        end else begin
                            state       <= ST_DONE;
                            hreadyout_o <= 1'b1;
                            hresp_o     <= HRESP_OKAY;
                        end
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_o <= 1'b1;
                    hresp_o     <= HRESP_ERROR;
                end
                default: begin
                    state       <= ST_IDLE;
                    hreadyout_o <= 1'b1;
                    hresp_o     <= HRESP_OKAY;
                    obi_req_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2obi_adapter.sv
// Directed self-checking bench for ahb2obi_adapter; expectations follow AHB2OBI_ERR_EN when defined.
module tb_ahb2obi_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic        obi_err;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    logic [31:0] hs_addr [$];

    always #5 clk = ~clk;

    // Single-slave bus: HREADY follows this slave's HREADYOUT.
    assign hready = hreadyout;

    ahb2obi_adapter #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
        .hclk_i(clk), .hreset_i(rst), .hsel_i(hsel), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
        .hwdata_i(hwdata), .hready_i(hready), .hreadyout_o(hreadyout),
        .hresp_o(hresp), .hrdata_o(hrdata), .obi_req_o(obi_req), .obi_gnt_i(obi_gnt),
        .obi_addr_o(obi_addr), .obi_we_o(obi_we), .obi_be_o(obi_be),
        .obi_wdata_o(obi_wdata), .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata),
        .obi_err_i(obi_err)
    );

    always @(posedge clk) begin
        if (!rst && obi_req && obi_gnt) begin
            hs_cnt = hs_cnt + 1;
            hs_addr.push_back(obi_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel   = 1'b1;
        haddr  = a;
        htrans = 2'b10;
        hwrite = w;
        hsize  = sz;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy"}, {31'b0, hreadyout}, 32'd1);
        check({tag, "_resp"}, {30'b0, hresp}, 32'd0);
        check({tag, "_req"}, {31'b0, obi_req}, 32'd0);
    endtask

    initial begin
        int base;
        rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; hburst = 3'd0; hwdata = '0; obi_gnt = 1'b0;
        obi_rvalid = 1'b0; obi_rdata = '0; obi_err = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        check_idle("reset");
        check("reset_rdata", hrdata, 32'h0);
        check("reset_we", {31'b0, obi_we}, 32'd0);
        check("reset_be", {28'b0, obi_be}, 32'd0);
        check("reset_addr", obi_addr, 32'h0);

        // Word write, zero-wait gnt and rvalid.
        addr_phase(32'h104, 1'b1, 3'd2);
        step();
        bus_idle(); hwdata = 32'hDEADBEEF; obi_gnt = 1'b1; #1;
        check("wr_req", {31'b0, obi_req}, 32'd1);
        check("wr_addr", obi_addr, 32'h104);
        check("wr_be", {28'b0, obi_be}, 32'hF);
        check("wr_we", {31'b0, obi_we}, 32'd1);
        check("wr_wdata", obi_wdata, 32'hDEADBEEF);
        check("wr_rdy1", {31'b0, hreadyout}, 32'd0);
        step();
        obi_gnt = 1'b0; obi_rvalid = 1'b1;
        check("wr_req_drop", {31'b0, obi_req}, 32'd0);
        check("wr_rdy2", {31'b0, hreadyout}, 32'd0);
        step();
        obi_rvalid = 1'b0;
        check("wr_rdy3", {31'b0, hreadyout}, 32'd1);
        check("wr_resp", {30'b0, hresp}, 32'd0);

        // Byte read at 0x103.
        addr_phase(32'h103, 1'b0, 3'd0);
        step();
        bus_idle(); obi_gnt = 1'b1;
        check("rdb_addr", obi_addr, 32'h100);
        check("rdb_be", {28'b0, obi_be}, 32'h8);
        check("rdb_we", {31'b0, obi_we}, 32'd0);
        step();
        obi_gnt = 1'b0; obi_rvalid = 1'b1; obi_rdata = 32'h11223344;
        step();
        obi_rvalid = 1'b0;
        check("rdb_rdy", {31'b0, hreadyout}, 32'd1);
        check("rdb_rdata", hrdata, 32'h11223344);
        check("rdb_resp", {30'b0, hresp}, 32'd0);
        step();

        // Back-to-back reads with two cycles of grant delay each.
        base = hs_cnt;
        addr_phase(32'h0, 1'b0, 3'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            if (k < 2) addr_phase(32'(k * 4 + 4), 1'b0, 3'd2);
            else bus_idle();
            check($sformatf("b2b%0d_req1", k), {31'b0, obi_req}, 32'd1);
            check($sformatf("b2b%0d_addr", k), obi_addr, 32'(k * 4));
            check($sformatf("b2b%0d_rdy1", k), {31'b0, hreadyout}, 32'd0);
            step();
            check($sformatf("b2b%0d_req2", k), {31'b0, obi_req}, 32'd1);
            step();
            check($sformatf("b2b%0d_req3", k), {31'b0, obi_req}, 32'd1);
            check($sformatf("b2b%0d_rdy3", k), {31'b0, hreadyout}, 32'd0);
            obi_gnt = 1'b1;
            step();
            obi_gnt = 1'b0; obi_rvalid = 1'b1; obi_rdata = 32'hA000_0000 + 32'(k);
            check($sformatf("b2b%0d_rsp_req", k), {31'b0, obi_req}, 32'd0);
            check($sformatf("b2b%0d_rsp_rdy", k), {31'b0, hreadyout}, 32'd0);
            step();
            obi_rvalid = 1'b0;
            check($sformatf("b2b%0d_done_rdy", k), {31'b0, hreadyout}, 32'd1);
            check($sformatf("b2b%0d_rdata", k), hrdata, 32'hA000_0000 + 32'(k));
        end
        step();
        check("b2b_hs_count", 32'(hs_cnt - base), 32'd3);
        for (int k = 0; k < 3; k++)
            check($sformatf("b2b_hs_addr%0d", k), hs_addr[base + k], 32'(k * 4));
        check_idle("b2b_end");

        // OBI error on rvalid.
        addr_phase(32'h10, 1'b0, 3'd2);
        step();
        bus_idle(); obi_gnt = 1'b1;
        step();
        obi_gnt = 1'b0; obi_rvalid = 1'b1; obi_err = 1'b1; obi_rdata = 32'h5;
        step();
        obi_rvalid = 1'b0; obi_err = 1'b0;
`ifdef AHB2OBI_ERR_EN
        check("err_c1_resp", {30'b0, hresp}, 32'd1);
        check("err_c1_rdy", {31'b0, hreadyout}, 32'd0);
        step();
        check("err_c2_resp", {30'b0, hresp}, 32'd1);
        check("err_c2_rdy", {31'b0, hreadyout}, 32'd1);
`else
        check("err_off_resp", {30'b0, hresp}, 32'd0);
        check("err_off_rdy", {31'b0, hreadyout}, 32'd1);
        step();
`endif
        step();
        check_idle("err_end");

        // Misaligned half-word at 0x1.
        base = hs_cnt;
        addr_phase(32'h1, 1'b0, 3'd1);
        step();
        bus_idle();
`ifdef AHB2OBI_ERR_EN
        check("mis_req", {31'b0, obi_req}, 32'd0);
        check("mis_c1_resp", {30'b0, hresp}, 32'd1);
        check("mis_c1_rdy", {31'b0, hreadyout}, 32'd0);
        step();
        check("mis_c2_resp", {30'b0, hresp}, 32'd1);
        check("mis_c2_rdy", {31'b0, hreadyout}, 32'd1);
        step();
        check("mis_hs", 32'(hs_cnt - base), 32'd0);
`else
        check("mis_req", {31'b0, obi_req}, 32'd1);
        check("mis_be", {28'b0, obi_be}, 32'h3);
        check("mis_addr", obi_addr, 32'h0);
        obi_gnt = 1'b1;
        step();
        obi_gnt = 1'b0; obi_rvalid = 1'b1;
        step();
        obi_rvalid = 1'b0;
        check("mis_resp", {30'b0, hresp}, 32'd0);
        check("mis_rdy", {31'b0, hreadyout}, 32'd1);
        check("mis_hs", 32'(hs_cnt - base), 32'd1);
        step();
`endif
        check_idle("mis_end");

        // Reset while the request is still waiting for grant.
        addr_phase(32'h40, 1'b0, 3'd2);
        step();
        bus_idle();
        check("rstreq_req", {31'b0, obi_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rstreq");

        // Reset in RSP, then a stale rvalid, then a normal transfer.
        addr_phase(32'h20, 1'b0, 3'd2);
        step();
        bus_idle(); obi_gnt = 1'b1;
        step();
        obi_gnt = 1'b0; rst = 1'b1;
        check("rstrsp_rdy", {31'b0, hreadyout}, 32'd0);
        step();
        rst = 1'b0;
        check_idle("rstrsp");
        obi_rvalid = 1'b1; obi_rdata = 32'hBAD0BAD0;
        step();
        obi_rvalid = 1'b0;
        check_idle("late_rv");
        check("late_rv_rdata", hrdata, 32'h0);
        addr_phase(32'h30, 1'b1, 3'd2);
        step();
        bus_idle(); hwdata = 32'hCAFEF00D; obi_gnt = 1'b1; #1;
        check("post_addr", obi_addr, 32'h30);
        check("post_wdata", obi_wdata, 32'hCAFEF00D);
        step();
        obi_gnt = 1'b0; obi_rvalid = 1'b1;
        step();
        obi_rvalid = 1'b0;
        check("post_rdy", {31'b0, hreadyout}, 32'd1);
        check("post_resp", {30'b0, hresp}, 32'd0);

        // IDLE and BUSY with select high produce no OBI activity.
        base = hs_cnt;
        hsel = 1'b1; haddr = 32'h50; htrans = 2'b00;
        step();
        check_idle("htrans_idle");
        htrans = 2'b01;
        step();
        check_idle("htrans_busy1");
        step();
        check_idle("htrans_busy2");
        check("htrans_hs", 32'(hs_cnt - base), 32'd0);
        bus_idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
